csel_adder_pipe: RTL and testbench
==================================

Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder; next generation of the fixed 28-bit MAC accumulation adder.
- Sums a sign-extended narrow operand (product) with a wide operand (running sum), or with its own internal accumulator.
- Segments are grouped into pipeline stages, so a MAC datapath can close timing at wider widths.
- Valid/ready on input and output, with full-pipeline back-pressure.

Parameters:
- IN_A_W, 27, width of narrow signed operand in_a; must be ≤ SUM_W.
- SUM_W, 28, width of in_b, sum and accumulator; must be a multiple of SEG_W.
- SEG_W, 4, bits per carry-select segment.
- SEGS_PER_STAGE, 2, segments resolved per pipeline stage.
- Derived: NSEG = SUM_W/SEG_W. NSTG = ceil(NSEG/SEGS_PER_STAGE). Latency L = NSTG (defaults: 7 segments, 4 stages).

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: input operation valid.
- in_ready, out, 1: input accepted when in_valid && in_ready.
- in_a, in, IN_A_W: signed operand, sign-extended to SUM_W.
- in_b, in, SUM_W: second operand; ignored when in_acc=1.
- in_acc, in, 1: 1 = second operand is acc_q (accumulate op).
- in_clr, in, 1: synchronous accumulator clear.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- out_sum, out, SUM_W: sum modulo 2^SUM_W.
- out_cout, out, 1: carry out of bit SUM_W-1.
- out_ovf, out, 1: signed overflow.
- acc_q, out, SUM_W: accumulator register.

Behaviour:
- Reset (async assert, sync release): all stage valids 0, out_valid 0, out_sum/out_cout/out_ovf 0, acc_q 0, acc_busy 0, in_ready 0 while rst_n=0. In-flight operations are discarded.
- Advance: adv = !(out_valid && !out_ready). Every stage register updates only when adv=1; otherwise the whole pipe holds. No bubble collapsing.
- in_ready = adv && !acc_busy.
- Stage k computes segments k*SEGS_PER_STAGE onward.
  - Per segment: sum0/carry0 with cin=0 and sum1/carry1 with cin=1, muxed by the incoming carry.
  - Stage 0 carry-in is 0.
  - Each stage registers: resolved sum bits, carry to the next stage, unconsumed upper operand bits, valid.
- Last stage drives the outputs:
  - out_cout = final carry.
  - out_ovf = (a_ext[MSB]==b[MSB]) && (sum[MSB]!=a_ext[MSB]).
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+L when the pipe is not stalled. Full throughput is 1 op/cycle.
- Accumulate hazard:
  - Accepting an op with in_acc=1 samples acc_q as the operand and sets acc_busy.
  - acc_busy clears on the output handshake of that op.
  - Non-acc ops already in flight are unaffected.
- Accumulator write-back: on the output handshake of an acc op, acc_q <= out_sum.
- Clear: in_clr=1 sets acc_q <= 0 next edge regardless of valid. If it coincides with an acc write-back, clear wins.
- An acc op accepted in the same cycle as in_clr samples the pre-clear acc_q.
- Sum is modular: wrap-around is silent apart from the cout/ovf flags.
- Outputs hold stable while out_valid && !out_ready.

Test Plan:
- in_a=27'h0000001, in_b=28'h000000F, in_acc=0, out_ready=1 → 4 cycles later out_sum=28'h0000010, cout=0, ovf=0.
- in_a=27'h7FFFFFF (−1), in_b=28'h0000001 → out_sum=28'h0000000, cout=1, ovf=0. Checks sign extension and carry across all 7 segments.
- in_a=27'h3FFFFFF, in_b=28'h7FFFFFF → out_sum=28'hBFFFFFE, cout=0, ovf=1.
- 8 back-to-back ops with sums 1..8; out_ready low for 3 cycles after the first result → in_ready=0 during the stall, all 8 results delivered in order, none lost or duplicated, out_sum stable while stalled.
- in_clr pulse, then acc ops in_a=5, 3, 27'h7FFFFFE (−2) → acc_q=5, 8, 6. in_ready=0 from each acc accept until its handshake, so the next accept is ≥4 cycles later. in_clr coincident with the third write-back → acc_q=0.
- Drop rst_n with 3 ops in flight → out_valid and acc_q go to 0 immediately, without waiting for a clock edge. After release, no stale results emerge and a fresh 1+1 returns 2 at latency 4.

Source files
------------

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder: sign-extended narrow operand plus a wide operand or the
// internal accumulator, resolving SEGS_PER_STAGE carry-select segments per pipeline stage.
module csel_adder_pipe #(
  parameter int unsigned IN_A_W         = 27,
  parameter int unsigned SUM_W          = 28,
  parameter int unsigned SEG_W          = 4,
  parameter int unsigned SEGS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_A_W-1:0] in_a,
  input  logic [SUM_W-1:0] in_b,
  input  logic             in_acc,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [SUM_W-1:0] acc_q
);

  localparam int unsigned NumSeg  = SUM_W / SEG_W;
  localparam int unsigned NumStg  = (NumSeg + SEGS_PER_STAGE - 1) / SEGS_PER_STAGE;
  localparam int unsigned LastStg = NumStg - 1;
  localparam int unsigned Msb     = SUM_W - 1;

  logic             adv;
  logic             in_fire;
  logic             out_fire;
  logic             out_is_acc;
  logic             acc_busy_q, acc_busy_d;
  logic [SUM_W-1:0] acc_d;

  // Operand capture register in front of the adder stages.
  logic             op_valid_q, op_valid_d;
  logic             op_acc_q, op_acc_d;
  logic [SUM_W-1:0] op_a_q, op_a_d;
  logic [SUM_W-1:0] op_b_q, op_b_d;

  logic             st_valid_q [NumStg];
  logic             st_valid_d [NumStg];
  logic             st_acc_q   [NumStg];
  logic             st_acc_d   [NumStg];
  logic             st_carry_q [NumStg];
  logic             st_carry_d [NumStg];
  logic [SUM_W-1:0] st_a_q     [NumStg];
  logic [SUM_W-1:0] st_a_d     [NumStg];
  logic [SUM_W-1:0] st_b_q     [NumStg];
  logic [SUM_W-1:0] st_b_d     [NumStg];
  logic [SUM_W-1:0] st_sum_q   [NumStg];
  logic [SUM_W-1:0] st_sum_d   [NumStg];

  // Stage-evaluation temporaries.
  logic             cur_valid;
  logic             cur_acc;
  logic             cur_carry;
  logic [SUM_W-1:0] cur_a;
  logic [SUM_W-1:0] cur_b;
  logic [SUM_W-1:0] cur_sum;
  logic [SEG_W-1:0] seg_a;
  logic [SEG_W-1:0] seg_b;
  logic [SEG_W:0]   res0;
  logic [SEG_W:0]   res1;
  int unsigned      seg;
  int unsigned      base;
  int unsigned      prv;

  // The whole pipe freezes while a result waits for the consumer.
  assign adv        = !(out_valid && !out_ready);
  assign in_ready   = rst_n && adv && !acc_busy_q;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign out_is_acc = st_acc_q[LastStg];

  always_comb begin
    op_valid_d = in_fire;
    op_acc_d   = op_acc_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    if (in_fire) begin
      op_acc_d = in_acc;
      op_a_d   = SUM_W'($signed(in_a));
      op_b_d   = in_acc ? acc_q : in_b;
    end
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_acc   = 1'b0;
    cur_carry = 1'b0;
    cur_a     = '0;
    cur_b     = '0;
    cur_sum   = '0;
    seg_a     = '0;
    seg_b     = '0;
    res0      = '0;
    res1      = '0;
    seg       = 0;
    base      = 0;
    prv       = 0;
    for (int unsigned k = 0; k < NumStg; k++) begin
      prv = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        cur_valid = op_valid_q;
        cur_acc   = op_acc_q;
        cur_a     = op_a_q;
        cur_b     = op_b_q;
        cur_sum   = '0;
        cur_carry = 1'b0;
      end else begin
        cur_valid = st_valid_q[prv];
        cur_acc   = st_acc_q[prv];
        cur_a     = st_a_q[prv];
        cur_b     = st_b_q[prv];
        cur_sum   = st_sum_q[prv];
        cur_carry = st_carry_q[prv];
      end
      for (int unsigned j = 0; j < SEGS_PER_STAGE; j++) begin
        seg = k * SEGS_PER_STAGE + j;
        if (seg < NumSeg) begin
          base  = seg * SEG_W;
          seg_a = cur_a[base +: SEG_W];
          seg_b = cur_b[base +: SEG_W];
          // Both carry-in hypotheses are formed up front; the ripple only drives the mux.
          res0  = {1'b0, seg_a} + {1'b0, seg_b};
          res1  = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, 1'b1};
          {cur_carry, cur_sum[base +: SEG_W]} = cur_carry ? res1 : res0;
        end
      end
      st_valid_d[k] = cur_valid;
      st_acc_d[k]   = cur_acc;
      st_carry_d[k] = cur_carry;
      st_a_d[k]     = cur_a;
      st_b_d[k]     = cur_b;
      st_sum_d[k]   = cur_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op_acc_q   <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      for (int unsigned k = 0; k < NumStg; k++) begin
        st_valid_q[k] <= 1'b0;
        st_acc_q[k]   <= 1'b0;
        st_carry_q[k] <= 1'b0;
        st_a_q[k]     <= '0;
        st_b_q[k]     <= '0;
        st_sum_q[k]   <= '0;
      end
    end else if (adv) begin
      op_valid_q <= op_valid_d;
      op_acc_q   <= op_acc_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      for (int unsigned k = 0; k < NumStg; k++) begin
        st_valid_q[k] <= st_valid_d[k];
        st_acc_q[k]   <= st_acc_d[k];
        st_carry_q[k] <= st_carry_d[k];
        st_a_q[k]     <= st_a_d[k];
        st_b_q[k]     <= st_b_d[k];
        st_sum_q[k]   <= st_sum_d[k];
      end
    end
  end

  always_comb begin
    acc_d      = acc_q;
    acc_busy_d = acc_busy_q;
    if (out_fire && out_is_acc) begin
      acc_d      = out_sum;
      acc_busy_d = 1'b0;
    end
    // Clear has priority over a coinciding write-back.
    if (in_clr) begin
      acc_d = '0;
    end
    if (in_fire && in_acc) begin
      acc_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      acc_busy_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_busy_q <= acc_busy_d;
    end
  end

  assign out_valid = st_valid_q[LastStg];
  assign out_sum   = st_sum_q[LastStg];
  assign out_cout  = st_carry_q[LastStg];
  assign out_ovf   = (st_a_q[LastStg][Msb] == st_b_q[LastStg][Msb]) &&
                     (st_sum_q[LastStg][Msb] != st_a_q[LastStg][Msb]);

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed bench for csel_adder_pipe: vector table, stalled stream, accumulator hazard, reset.
module tb_csel_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_a;
  logic [27:0] in_b;
  logic        in_acc;
  logic        in_clr;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic [27:0] acc_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  csel_adder_pipe #(
    .IN_A_W(27),
    .SUM_W(28),
    .SEG_W(4),
    .SEGS_PER_STAGE(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_acc(in_acc),
    .in_clr(in_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_cout(out_cout),
    .out_ovf(out_ovf),
    .acc_q(acc_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [26:0] a;
    logic [27:0] b;
    logic [27:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_single(input string name, input logic [26:0] a, input logic [27:0] b,
                            input logic [27:0] es, input logic ec, input logic eo);
    int g;
    int lat;
    @(negedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_acc    = 1'b0;
    in_a      = a;
    in_b      = b;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, lat, 4);
    chk({name, " sum"}, out_sum, es);
    chk({name, " cout"}, out_cout, ec);
    chk({name, " ovf"}, out_ovf, eo);
    @(posedge clk); #1;
  endtask

  task automatic do_acc(input string name, input logic [26:0] a, input bit clr_acc,
                        input bit clr_wb, input logic [27:0] exp_sum, input logic exp_cout,
                        input logic [27:0] exp_acc, output int acc_cyc);
    int g;
    int leak;
    @(negedge clk); #1;
    in_valid = 1'b1;
    in_acc   = 1'b1;
    in_a     = a;
    in_b     = 28'hAAAAAAA;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk); #1;
      g++;
    end
    chk({name, " accept"}, in_ready, 1);
    acc_cyc = cyc;
    in_clr  = clr_acc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_acc   = 1'b0;
    in_clr   = 1'b0;
    if (clr_acc) chk({name, " clr at accept"}, acc_q, 0);
    leak = 0;
    g = 0;
    while (!out_valid && g < 20) begin
      if (in_ready) leak++;
      @(negedge clk); #1;
      g++;
    end
    chk({name, " busy blocks input"}, leak, 0);
    chk({name, " sum"}, out_sum, exp_sum);
    chk({name, " cout"}, out_cout, exp_cout);
    in_clr = clr_wb;
    @(posedge clk); #1;
    in_clr = 1'b0;
    chk({name, " acc_q"}, acc_q, exp_acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int extra;
    int stale;
    int g;
    int c0, c1, c2;

    vecs[0] = '{"small",      27'h0000001, 28'h000000F, 28'h0000010, 1'b0, 1'b0};
    vecs[1] = '{"neg1_plus1", 27'h7FFFFFF, 28'h0000001, 28'h0000000, 1'b1, 1'b0};
    vecs[2] = '{"pos_ovf",    27'h3FFFFFF, 28'h7FFFFFF, 28'hBFFFFFE, 1'b0, 1'b1};
    vecs[3] = '{"neg_ovf",    27'h4000000, 28'h8000000, 28'h4000000, 1'b1, 1'b1};
    vecs[4] = '{"mixed",      27'h1234567, 28'h0FEDCBA, 28'h2222221, 1'b0, 1'b0};
    vecs[5] = '{"cancel",     27'h0000005, 28'hFFFFFFB, 28'h0000000, 1'b1, 1'b0};
    vecs[6] = '{"neg_wrap",   27'h7FFFFFF, 28'h8000000, 28'h7FFFFFF, 1'b1, 1'b1};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_acc    = 1'b0;
    in_clr    = 1'b0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset acc_q", acc_q, 0);
    chk("reset out_sum", out_sum, 0);
    chk("reset out_cout", out_cout, 0);
    chk("reset out_ovf", out_ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_single(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
    end

    // Eight back-to-back ops, consumer stalls three cycles on the first result.
    got = 0;
    fork
      begin
        int gd;
        for (int i = 1; i <= 8; i++) begin
          in_valid = 1'b1;
          in_acc   = 1'b0;
          in_a     = 27'(i);
          in_b     = '0;
          gd = 0;
          do begin
            @(negedge clk); #1;
            gd++;
          end while (!in_ready && gd < 100);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        int stall_left;
        int cm;
        logic [27:0] held;
        bit stalled;
        stall_left = 0;
        stalled = 1'b0;
        held = '0;
        cm = 0;
        out_ready = 1'b1;
        while (got < 8 && cm < 200) begin
          @(negedge clk);
          cm++;
          if (out_valid) begin
            if (!stalled) begin
              stalled = 1'b1;
              stall_left = 3;
              held = out_sum;
            end else if (stall_left > 0) begin
              chk("stall hold sum", out_sum, held);
              chk("stall in_ready", in_ready, 0);
            end
            if (stall_left > 0) begin
              out_ready = 1'b0;
              stall_left--;
            end else begin
              out_ready = 1'b1;
              chk("stream order", out_sum, got + 1);
              got++;
            end
          end else begin
            out_ready = 1'b1;
          end
        end
      end
    join
    chk("stream count", got, 8);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("stream no extra", extra, 0);

    // Accumulator sequence.
    @(negedge clk); #1;
    in_clr = 1'b1;
    @(posedge clk); #1;
    in_clr = 1'b0;
    chk("clr pulse acc_q", acc_q, 0);
    do_acc("acc1", 27'd5, 1'b0, 1'b0, 28'd5, 1'b0, 28'd5, c0);
    do_acc("acc2", 27'd3, 1'b0, 1'b0, 28'd8, 1'b0, 28'd8, c1);
    chk("acc gap 1-2", (c1 - c0) >= 4, 1);
    do_acc("acc3", 27'h7FFFFFE, 1'b0, 1'b1, 28'd6, 1'b1, 28'd0, c2);
    chk("acc gap 2-3", (c2 - c1) >= 4, 1);
    do_acc("acc4", 27'd5, 1'b0, 1'b0, 28'd5, 1'b0, 28'd5, c0);
    do_acc("acc5 clr same cycle", 27'd1, 1'b1, 1'b0, 28'd6, 1'b0, 28'd6, c1);

    // Reset with ops in flight and a result held at the output.
    @(negedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_acc    = 1'b0;
    in_b      = 28'h0000100;
    for (int i = 0; i < 3; i++) begin
      in_a = 27'(10 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 20) begin
      @(negedge clk); #1;
      g++;
    end
    chk("pre-reset out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset acc_q", acc_q, 0);
    chk("async reset out_sum", out_sum, 0);
    chk("async reset in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no stale results", stale, 0);
    run_single("post-reset", 27'd1, 28'd1, 28'd2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
